// File: rtl/ep_cpl_sched.sv
// rtl/ep_cpl_sched.sv - non-posted completion scheduler: descriptor FIFO, write fence, UR range check
module ep_cpl_sched #(
  parameter int DEPTH     = 8,
  parameter int PROG_FULL = 6,
  parameter int ADDR_W    = 13,
  parameter int MEM_WORDS = 2048,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_compl_i,
  input  logic              req_compl_with_data_i,
  input  logic [2:0]        req_tc_i,
  input  logic              req_td_i,
  input  logic              req_ep_i,
  input  logic [1:0]        req_attr_i,
  input  logic [9:0]        req_len_i,
  input  logic [15:0]       req_rid_i,
  input  logic [7:0]        req_tag_i,
  input  logic [7:0]        req_be_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              to_rxe_compl_done_o,
  output logic              rx_np_ok,
  input  logic              wr_pending_i,
  output logic              req_compl_o,
  output logic              req_compl_with_data_o,
  output logic [2:0]        cpl_status_o,
  output logic [2:0]        req_tc_o,
  output logic              req_td_o,
  output logic              req_ep_o,
  output logic [1:0]        req_attr_o,
  output logic [9:0]        req_len_o,
  output logic [15:0]       req_rid_o,
  output logic [7:0]        req_tag_o,
  output logic [7:0]        req_be_o,
  output logic [ADDR_W-1:0] req_addr_o,
  input  logic              txe_compl_done_i,
  output logic [CW-1:0]     count_o,
  output logic              overflow_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Sum width must hold both the DW address and a 1024-DW length without wrapping.
  localparam int SW = (ADDR_W + 1 > 12) ? ADDR_W + 1 : 12;
  localparam logic [SW-1:0] MEM_LIM = SW'(MEM_WORDS);

  typedef struct packed {
    logic              wd;
    logic              ur;
    logic              fence;
    logic [2:0]        tc;
    logic              td;
    logic              ep;
    logic [1:0]        attr;
    logic [9:0]        len;
    logic [15:0]       rid;
    logic [7:0]        tag;
    logic [7:0]        be;
    logic [ADDR_W-1:0] addr;
  } desc_t;

  typedef enum logic [1:0] {IDLE, FENCE, ISSUE} state_t;

  desc_t            mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             done_q;
  logic             ovf_q, ovf_d;
  logic             np_ok_q;
  state_t           state_q, state_d;

  logic             push, pop;
  logic [SW-1:0]    dw_ext, len_ext, end_dw;
  logic             is_ur;
  desc_t            new_desc, head;
  logic             show;

  always_comb begin
    dw_ext  = SW'(req_addr_i[ADDR_W-1:2]);
    len_ext = (req_len_i == 10'd0) ? SW'(1024) : SW'(req_len_i);
    end_dw  = dw_ext + len_ext;
    is_ur   = req_compl_with_data_i && (end_dw > MEM_LIM);
  end

  always_comb begin
    new_desc       = '0;
    new_desc.wd    = req_compl_with_data_i && !is_ur;
    new_desc.ur    = is_ur;
    new_desc.fence = wr_pending_i;
    new_desc.tc    = req_tc_i;
    new_desc.td    = req_td_i;
    new_desc.ep    = req_ep_i;
    new_desc.attr  = req_attr_i;
    new_desc.len   = is_ur ? 10'd0 : req_len_i;
    new_desc.rid   = req_rid_i;
    new_desc.tag   = req_tag_i;
    new_desc.be    = req_be_i;
    new_desc.addr  = req_addr_i;
  end

  // Acceptance uses the registered count, so a full FIFO refuses even if a pop is in flight.
  assign push = req_compl_i && (count_q < CW'(DEPTH));
  assign pop  = (state_q == ISSUE) && txe_compl_done_i;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    ovf_d = ovf_q || (req_compl_i && !push);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_desc;
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (count_q != '0) state_d = FENCE;
      FENCE:   if (!head.fence || !wr_pending_i) state_d = ISSUE;
      ISSUE:   if (txe_compl_done_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      np_ok_q  <= 1'b1;
      state_q  <= IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      done_q   <= push;
      ovf_q    <= ovf_d;
      np_ok_q  <= (count_d < CW'(PROG_FULL));
      state_q  <= state_d;
    end
  end

  // Head fields are only exposed once the FSM has latched onto an entry.
  assign show = (state_q != IDLE);

  assign to_rxe_compl_done_o   = done_q;
  assign rx_np_ok              = np_ok_q;
  assign count_o               = count_q;
  assign overflow_o            = ovf_q;
  assign req_compl_o           = (state_q == ISSUE);
  assign req_compl_with_data_o = show && head.wd;
  assign cpl_status_o          = (show && head.ur) ? 3'b001 : 3'b000;
  assign req_tc_o              = show ? head.tc   : '0;
  assign req_td_o              = show && head.td;
  assign req_ep_o              = show && head.ep;
  assign req_attr_o            = show ? head.attr : '0;
  assign req_len_o             = show ? head.len  : '0;
  assign req_rid_o             = show ? head.rid  : '0;
  assign req_tag_o             = show ? head.tag  : '0;
  assign req_be_o              = show ? head.be   : '0;
  assign req_addr_o            = show ? head.addr : '0;

endmodule

// File: doc/ep_cpl_sched.md
Name: ep_cpl_sched

Overview:
Parametrised non-posted completion scheduler for the PCIe endpoint memory path. It sits between the RX engine and the TX engine. Read requests are queued in an internal DEPTH-entry descriptor FIFO, which replaces the fixed vendor command FIFO. rx_np_ok is driven from a programmable threshold. Each completion waits behind any posted write that was in flight when its read arrived. Reads outside the memory window get an Unsupported Request (UR) completion.

Parameters:
DEPTH, 8, descriptor FIFO entries; power of two, 2..64
PROG_FULL, 6, occupancy at which rx_np_ok deasserts; 1..DEPTH
ADDR_W, 13, request byte-address width
MEM_WORDS, 2048, DW size of the backing memory; used for the range check
CW, log2(DEPTH)+1, occupancy counter width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_compl_i  in  1  RX engine: 1-cycle request strobe
req_compl_with_data_i  in  1  1=CplD (read), 0=Cpl
req_tc_i  in  3  traffic class
req_td_i  in  1  TLP digest
req_ep_i  in  1  poisoned
req_attr_i  in  2  attributes
req_len_i  in  10  length in DW (0 encodes 1024)
req_rid_i  in  16  requester ID
req_tag_i  in  8  tag
req_be_i  in  8  first/last byte enables
req_addr_i  in  ADDR_W  byte address
to_rxe_compl_done_o  out  1  accept pulse to RX engine
rx_np_ok  out  1  RX may deliver further non-posted TLPs
wr_pending_i  in  1  posted write to memory not yet committed
req_compl_o  out  1  TX engine: completion request (level)
req_compl_with_data_o  out  1  CplD select
cpl_status_o  out  3  000=SC, 001=UR
req_tc_o/td_o/ep_o/attr_o/len_o/rid_o/tag_o/be_o/addr_o  out  as inputs  head descriptor fields
txe_compl_done_i  in  1  TX engine: completion sent
count_o  out  CW  FIFO occupancy
overflow_o  out  1  sticky; set when a request arrives while the FIFO is full

Behaviour:
- Reset values: all outputs 0 except rx_np_ok=1. FSM goes to IDLE. FIFO is emptied.
- Push occurs on req_compl_i while count_o<DEPTH, using registered count.
  - Stored entry: all fields, with_data, ur, fence.
  - fence = wr_pending_i sampled in the push cycle.
  - to_rxe_compl_done_o pulses one cycle later, for exactly one cycle.
- Push while full: request dropped, no done pulse, overflow_o set. overflow_o clears only on reset.
- Range check, applied at push:
  - With dw = addr[ADDR_W-1:2] and L = len (0 treated as 1024), the request is UR when with_data=1 and dw+L > MEM_WORDS.
  - Compute dw+L at ADDR_W+1 bits so it cannot wrap.
  - UR entry: ur=1, with_data forced 0, len stored as 0.
- rx_np_ok is registered: next = (count_next < PROG_FULL).
- count_o: +1 on push, -1 on pop, unchanged when both happen in the same cycle.
- Pointers wrap modulo DEPTH. full is derived from count, not from pointer equality.
- FSM states:
  - IDLE: if FIFO not empty, go to FENCE.
  - FENCE: head fields become valid on the outputs with req_compl_o=0. Go to ISSUE once head.fence==0 or wr_pending_i==0; the fence bit is evaluated once per entry.
  - ISSUE: req_compl_o=1; fields and cpl_status_o stay stable. On txe_compl_done_i: pop the head, deassert req_compl_o in the next cycle, go to IDLE.
- Minimum spacing is 3 cycles from one done to the next req_compl_o assertion.
- txe_compl_done_i outside ISSUE is ignored.
- Simultaneous push into an empty FIFO and an IDLE check: the new entry is seen the following cycle (no bypass).
- Reset mid-ISSUE: req_compl_o drops asynchronously and the queued entry is discarded.

Test Plan:
- Single read: addr=0x010, len=1, tag=0x05, wr_pending_i=0 → done pulse at T+1; req_compl_o=1 with tag_o=0x05, with_data=1, status 000 at T+3; a done returns count_o to 0.
- Fill: 8 back-to-back requests with txe_compl_done_i held 0, PROG_FULL=6 → rx_np_ok low after the 6th push; 8 done pulses; 9th request dropped with overflow_o=1 and no done pulse.
- Ordering: tags 1..8 queued, done acknowledged immediately each time → tag_o presented in order 1..8, 3-cycle spacing.
- Fence: push while wr_pending_i=1 and hold it for 10 cycles → req_compl_o stays 0 until 1 cycle after wr_pending_i falls. An entry pushed with wr_pending_i=0 issues without waiting.
- Range: addr=0x1FFC, len=2, with_data=1, MEM_WORDS=2048 → cpl_status_o=001, with_data_o=0, len_o=0. addr=0x1FFC, len=1 → status 000.
- Reset: assert rst_n=0 during ISSUE with 3 entries queued → req_compl_o=0 and count_o=0 immediately; rx_np_ok=1.
